fpu_add_subt_issuer: RTL and testbench

// Host-side initiator for the add/subtract FPU core. Accepts one operand pair per valid/ready request and drives the

---
 rtl/fpu_add_subt_issuer.sv | 128 ++++++++++++
 tb/tb_fpu_add_subt_issuer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_subt_issuer.sv
// Host-side issuer for the add/subtract FPU core.
// Accepts one operand pair per request and drives the core's start/release handshake.
// Returns the result, the latency and a timeout flag on a valid/ready response channel.
// Only one operation is outstanding at a time.
module fpu_add_subt_issuer #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [W-1:0]     req_op_a_i,
  input  logic [W-1:0]     req_op_b_i,
  input  logic             req_sub_i,
  output logic [W-1:0]     fpu_data_x_o,
  output logic [W-1:0]     fpu_data_y_o,
  output logic             fpu_add_subt_o,
  output logic             fpu_beg_o,
  output logic             fpu_rst_fsm_o,
  output logic             fpu_rst_o,
  input  logic             fpu_ready_i,
  input  logic [W-1:0]     fpu_result_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [W-1:0]     resp_result_o,
  output logic [CNT_W-1:0] resp_cycles_o,
  output logic             resp_timeout_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3,
    ABORT   = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment of the wait counter.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != '1) cnt_inc = cnt + 1'b1;
  end

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Control FSM with registered handshake pulses and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      fpu_data_x_o   <= '0;
      fpu_data_y_o   <= '0;
      fpu_add_subt_o <= 1'b0;
      fpu_beg_o      <= 1'b0;
      fpu_rst_fsm_o  <= 1'b0;
      fpu_rst_o      <= 1'b0;
      resp_valid_o   <= 1'b0;
      resp_result_o  <= '0;
      resp_cycles_o  <= '0;
      resp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            fpu_data_x_o   <= req_op_a_i;
            fpu_data_y_o   <= req_op_b_i;
            fpu_add_subt_o <= req_sub_i;
            cnt            <= '0;
            fpu_beg_o      <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          fpu_beg_o <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          // Ready wins over the timeout when both happen in the same cycle.
          if (fpu_ready_i) begin
            resp_result_o  <= fpu_result_i;
            resp_cycles_o  <= cnt_inc;
            resp_timeout_o <= 1'b0;
            fpu_rst_fsm_o  <= 1'b1;
            state          <= RELEASE;
          end else if (cnt == CNT_LAST) begin
            resp_result_o  <= '0;
            resp_cycles_o  <= cnt_inc;
            resp_timeout_o <= 1'b1;
            fpu_rst_o      <= 1'b1;
            state          <= ABORT;
          end
        end
        RELEASE: begin
          fpu_rst_fsm_o <= 1'b0;
          resp_valid_o  <= 1'b1;
          state         <= RESP;
        end
        ABORT: begin
          fpu_rst_o    <= 1'b0;
          resp_valid_o <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_subt_issuer.sv
// Directed self-checking bench for fpu_add_subt_issuer with a small latency model of the core.
module tb_fpu_add_subt_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_op_a;
  logic [31:0] req_op_b;
  logic        req_sub;
  logic [31:0] fpu_data_x;
  logic [31:0] fpu_data_y;
  logic        fpu_add_subt;
  logic        fpu_beg;
  logic        fpu_rst_fsm;
  logic        fpu_rst;
  logic        fpu_ready;
  logic [31:0] fpu_result;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [6:0]  resp_cycles;
  logic        resp_timeout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // core model state
  int unsigned lat_cnt;
  int unsigned model_lat;
  logic        stale_ready;
  logic [31:0] model_result;

  int beg_n  = 0;
  int rfsm_n = 0;
  int frst_n = 0;

  always #5 clk = ~clk;

  fpu_add_subt_issuer #(.W(32), .TIMEOUT(64), .CNT_W(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_a_i     (req_op_a),
    .req_op_b_i     (req_op_b),
    .req_sub_i      (req_sub),
    .fpu_data_x_o   (fpu_data_x),
    .fpu_data_y_o   (fpu_data_y),
    .fpu_add_subt_o (fpu_add_subt),
    .fpu_beg_o      (fpu_beg),
    .fpu_rst_fsm_o  (fpu_rst_fsm),
    .fpu_rst_o      (fpu_rst),
    .fpu_ready_i    (fpu_ready),
    .fpu_result_i   (fpu_result),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_result_o  (resp_result),
    .resp_cycles_o  (resp_cycles),
    .resp_timeout_o (resp_timeout),
    .busy_o         (busy)
  );

  // Core model: ready appears in the model_lat-th cycle after the beg pulse (never if 0).
  always @(posedge clk) begin
    if (rst) lat_cnt <= 0;
    else if (fpu_beg) lat_cnt <= model_lat;
    else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
  end
  assign fpu_ready  = (lat_cnt == 1) || stale_ready;
  assign fpu_result = model_result;

  // Count cycles each handshake pulse is high.
  always @(posedge clk) begin
    if (fpu_beg)     beg_n++;
    if (fpu_rst_fsm) rfsm_n++;
    if (fpu_rst)     frst_n++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for the response; leaves the bench in the first RESP cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input int unsigned lat, input logic [31:0] res, input logic [31:0] exp_res,
                       input int exp_cycles, input logic exp_to, input int exp_delay);
    int n;
    model_lat    = lat;
    model_result = res;
    check({tag, ".req_ready"}, req_ready, 1);
    req_op_a  = a;
    req_op_b  = b;
    req_sub   = sub;
    req_valid = 1'b1;
    tick();
    req_valid   = 1'b0;
    stale_ready = 1'b0;
    check({tag, ".beg"}, fpu_beg, 1);
    check({tag, ".x"}, fpu_data_x, a);
    check({tag, ".y"}, fpu_data_y, b);
    check({tag, ".op"}, fpu_add_subt, sub);
    n = 0;
    while (!resp_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".delay"}, n, exp_delay);
    check({tag, ".result"}, resp_result, exp_res);
    if (!exp_to) check({tag, ".cycles"}, resp_cycles, exp_cycles);
    check({tag, ".timeout"}, resp_timeout, exp_to);
    check({tag, ".x_hold"}, fpu_data_x, a);
  endtask

  initial begin
    int b0, r0, f0, vcnt;
    logic [31:0] hold;
    rst = 1'b1; req_valid = 1'b0; req_op_a = '0; req_op_b = '0; req_sub = 1'b0;
    resp_ready = 1'b1; stale_ready = 1'b0; model_lat = 0; model_result = '0;
    tick(); tick(); tick();
    check("rst.req_ready", req_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.outs", {fpu_beg, fpu_rst_fsm, fpu_rst, resp_valid, resp_timeout, fpu_add_subt}, 0);
    check("rst.data", {fpu_data_x, fpu_data_y, resp_result}, 0);
    rst = 1'b0;
    tick();

    // T1 add
    b0 = beg_n; r0 = rfsm_n; f0 = frst_n;
    do_op("t1", 32'h3F800000, 32'h40000000, 1'b0, 10, 32'h40400000, 32'h40400000, 10, 1'b0, 12);
    tick();
    check("t1.idle", {req_ready, resp_valid, busy}, 3'b100);
    check("t1.pulses", {beg_n - b0, rfsm_n - r0, frst_n - f0}, {32'd1, 32'd1, 32'd0});

    // T2 subtract
    do_op("t2", 32'h40400000, 32'h3F800000, 1'b1, 25, 32'h40000000, 32'h40000000, 25, 1'b0, 27);
    tick();

    // T3 timeout
    b0 = beg_n; r0 = rfsm_n; f0 = frst_n;
    do_op("t3", 32'h11111111, 32'h22222222, 1'b0, 0, 32'hDEADBEEF, 32'h0, 0, 1'b1, 66);
    tick();
    check("t3.pulses", {beg_n - b0, rfsm_n - r0, frst_n - f0}, {32'd1, 32'd0, 32'd1});

    // Ready on the last allowed WAIT cycle beats the timeout
    f0 = frst_n;
    do_op("edge", 32'h33333333, 32'h44444444, 1'b1, 64, 32'hCAFE0001, 32'hCAFE0001, 64, 1'b0, 66);
    tick();
    check("edge.frst", frst_n - f0, 0);

    // Zero-latency-like core: ready in the first WAIT cycle
    do_op("fast", 32'h0, 32'h0, 1'b0, 1, 32'h0, 32'h0, 1, 1'b0, 3);
    tick();

    // T4 backpressure
    resp_ready = 1'b0;
    do_op("t4", 32'h3F800000, 32'h3F800000, 1'b0, 5, 32'h12345678, 32'h12345678, 5, 1'b0, 7);
    hold = resp_result;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid && !req_ready && resp_result == hold && resp_cycles == 7'd5) vcnt++;
    end
    check("t4.held", vcnt, 5);
    resp_ready = 1'b1;
    tick();
    check("t4.done", {resp_valid, req_ready}, 2'b01);

    // T5 back-to-back with stale ready in IDLE
    b0 = beg_n; r0 = rfsm_n;
    stale_ready = 1'b1;
    tick(); tick();
    check("t5.stale_idle", {busy, resp_valid}, 0);
    do_op("t5a", 32'hA0000001, 32'hB0000001, 1'b0, 3, 32'h00000AAA, 32'h00000AAA, 3, 1'b0, 5);
    tick();
    stale_ready = 1'b1;
    do_op("t5b", 32'hA0000002, 32'hB0000002, 1'b1, 7, 32'h00000BBB, 32'h00000BBB, 7, 1'b0, 9);
    tick();
    stale_ready = 1'b1;
    do_op("t5c", 32'hA0000003, 32'hB0000003, 1'b0, 2, 32'h00000CCC, 32'h00000CCC, 2, 1'b0, 4);
    tick();
    check("t5.pulses", {beg_n - b0, rfsm_n - r0}, {32'd3, 32'd3});

    // T6 reset in WAIT at cnt=4
    f0 = frst_n; r0 = rfsm_n;
    model_lat = 20; model_result = 32'h55555555;
    req_op_a = 32'h77777777; req_op_b = 32'h88888888; req_sub = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t6.in_wait", {busy, fpu_beg, resp_valid}, 3'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6.state", {req_ready, busy}, 2'b10);
    check("t6.outs", {fpu_beg, fpu_rst_fsm, fpu_rst, resp_valid, resp_timeout, fpu_add_subt}, 0);
    check("t6.data", {fpu_data_x, fpu_data_y, resp_result}, 0);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (resp_valid || busy) vcnt++;
    end
    check("t6.no_resp", vcnt, 0);
    check("t6.pulses", {frst_n - f0, rfsm_n - r0}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
